// File: rtl/ps2_mouse_packet_ctrl.sv
// PS/2 mouse receive controller.
// Samples Ps2_Clk/Ps2_Data on Tick_En, frames 11-bit PS/2 words, assembles
// 3-byte movement packets and hands them to the LED logic via valid/ack.
// Build option: define MOUSE_OVF_SAT_EN to saturate an axis when its
// overflow bit in byte0 is set; otherwise the raw 9-bit deltas are passed on.
//
// Frame FSM
//   state     | meaning
//   F_IDLE    | waiting for a start bit (data 0 on a falling edge)
//   F_DATA    | shifting in 8 data bits, LSB first
//   F_PARITY  | capturing the odd-parity bit
//   F_STOP    | checking stop bit, handing the byte to the packet FSM
//
// Packet FSM
//   state     | meaning
//   P_BYTE0   | expecting header byte (bit3 must be 1)
//   P_BYTE1   | expecting X delta low byte
//   P_BYTE2   | expecting Y delta low byte; completion on good byte
module ps2_mouse_packet_ctrl #(
    parameter int FILT_LEN      = 4,
    parameter int TIMEOUT_TICKS = 2000
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Tick_En,
    input  logic       Ps2_Clk,
    input  logic       Ps2_Data,
    input  logic       Pkt_Ack,
    output logic       Pkt_Valid,
    output logic [2:0] Buttons,
    output logic [8:0] Dx,
    output logic [8:0] Dy,
    output logic       Err_Parity,
    output logic       Err_Frame,
    output logic       Pkt_Drop
);

    localparam int FCW = $clog2(FILT_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [FCW-1:0] FILT_LAST = FCW'(FILT_LEN - 1);
    localparam logic [TCW-1:0] TO_LOAD   = TCW'(TIMEOUT_TICKS);

    typedef enum logic [1:0] {F_IDLE, F_DATA, F_PARITY, F_STOP} frm_state_t;
    typedef enum logic [1:0] {P_BYTE0, P_BYTE1, P_BYTE2} pkt_state_t;

    logic           clk_s1, clk_s2, dat_s1, dat_s2;
    logic           clk_filt;
    logic [FCW-1:0] filt_cnt;
    logic           flip, fall_edge, bit_in;
    logic [TCW-1:0] to_cnt;
    logic           timeout;

    frm_state_t     frm_state, frm_next;
    pkt_state_t     pkt_state, pkt_next;
    logic [2:0]     bit_cnt, bit_cnt_next;
    logic [7:0]     shreg, shreg_next;
    logic           par_ok, par_ok_next;
    logic [4:0]     hdr_q, hdr_next;     // {sign_y, sign_x, buttons[2:0]}
    logic [7:0]     b1_q, b1_next;
`ifdef MOUSE_OVF_SAT_EN
    logic [1:0]     ovf_q, ovf_next;     // {ovf_y, ovf_x}
`endif
    logic           err_par_set, err_frm_set, pkt_done;
    logic [8:0]     dx_new, dy_new;

    // Two-flop synchronizers; lines idle high so reset to 1.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= Ps2_Clk;
            clk_s2 <= clk_s1;
            dat_s1 <= Ps2_Data;
            dat_s2 <= dat_s1;
        end
    end

    // The filtered level flips on the FILT_LEN-th consecutive tick at the new level.
    assign flip      = Tick_En && (clk_s2 != clk_filt) && (filt_cnt == FILT_LAST);
    assign fall_edge = flip && clk_filt;
    assign bit_in    = dat_s2;

    // Ps2_Clk glitch filter, advanced only on sampling ticks.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
        end else if (Tick_En) begin
            if (clk_s2 != clk_filt) begin
                if (filt_cnt == FILT_LAST) begin
                    clk_filt <= clk_s2;
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    // Inactivity timer: reloads on every falling edge, counts ticks down to zero.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            to_cnt <= TO_LOAD;
        end else if (fall_edge) begin
            to_cnt <= TO_LOAD;
        end else if (Tick_En && (to_cnt != '0)) begin
            to_cnt <= to_cnt - 1'b1;
        end
    end

    // Idle receiver with nothing pending has nothing to abort.
    assign timeout = Tick_En && !fall_edge && (to_cnt == TCW'(1))
                     && !((frm_state == F_IDLE) && (pkt_state == P_BYTE0));

    // Frame and packet sequencing; byte2 completes straight from the shift register.
    always_comb begin
        frm_next     = frm_state;
        pkt_next     = pkt_state;
        bit_cnt_next = bit_cnt;
        shreg_next   = shreg;
        par_ok_next  = par_ok;
        hdr_next     = hdr_q;
        b1_next      = b1_q;
`ifdef MOUSE_OVF_SAT_EN
        ovf_next     = ovf_q;
`endif
        err_par_set  = 1'b0;
        err_frm_set  = 1'b0;
        pkt_done     = 1'b0;
        if (timeout) begin
            frm_next = F_IDLE;
            pkt_next = P_BYTE0;
        end else if (fall_edge) begin
            case (frm_state)
                F_IDLE: begin
                    if (bit_in) begin
                        err_frm_set = 1'b1;
                    end else begin
                        frm_next     = F_DATA;
                        bit_cnt_next = 3'd0;
                    end
                end
                F_DATA: begin
                    shreg_next   = {bit_in, shreg[7:1]};
                    bit_cnt_next = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) frm_next = F_PARITY;
                end
                F_PARITY: begin
                    par_ok_next = ^{bit_in, shreg};
                    frm_next    = F_STOP;
                end
                F_STOP: begin
                    frm_next = F_IDLE;
                    if (!par_ok) begin
                        err_par_set = 1'b1;
                        pkt_next    = P_BYTE0;
                    end else if (!bit_in) begin
                        err_frm_set = 1'b1;
                        pkt_next    = P_BYTE0;
                    end else begin
                        case (pkt_state)
                            P_BYTE0: begin
                                if (!shreg[3]) begin
                                    err_frm_set = 1'b1;
                                end else begin
                                    hdr_next = {shreg[5:4], shreg[2:0]};
`ifdef MOUSE_OVF_SAT_EN
                                    ovf_next = shreg[7:6];
`endif
                                    pkt_next = P_BYTE1;
                                end
                            end
                            P_BYTE1: begin
                                b1_next  = shreg;
                                pkt_next = P_BYTE2;
                            end
                            P_BYTE2: begin
                                pkt_done = 1'b1;
                                pkt_next = P_BYTE0;
                            end
                            default: pkt_next = P_BYTE0;
                        endcase
                    end
                end
                default: frm_next = F_IDLE;
            endcase
        end
    end

    // Receiver state registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            frm_state <= F_IDLE;
            pkt_state <= P_BYTE0;
            bit_cnt   <= 3'd0;
            shreg     <= 8'd0;
            par_ok    <= 1'b1;
            hdr_q     <= 5'd0;
            b1_q      <= 8'd0;
`ifdef MOUSE_OVF_SAT_EN
            ovf_q     <= 2'd0;
`endif
        end else begin
            frm_state <= frm_next;
            pkt_state <= pkt_next;
            bit_cnt   <= bit_cnt_next;
            shreg     <= shreg_next;
            par_ok    <= par_ok_next;
            hdr_q     <= hdr_next;
            b1_q      <= b1_next;
`ifdef MOUSE_OVF_SAT_EN
            ovf_q     <= ovf_next;
`endif
        end
    end

    // Axis decode of the packet being completed.
    always_comb begin
        dx_new = {hdr_q[3], b1_q};
        dy_new = {hdr_q[4], shreg};
`ifdef MOUSE_OVF_SAT_EN
        if (ovf_q[0]) dx_new = hdr_q[3] ? 9'h100 : 9'h0FF;
        if (ovf_q[1]) dy_new = hdr_q[4] ? 9'h100 : 9'h0FF;
`endif
    end

    // Output hold register with valid/ack handshake and error pulses.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Pkt_Valid  <= 1'b0;
            Buttons    <= 3'd0;
            Dx         <= 9'd0;
            Dy         <= 9'd0;
            Err_Parity <= 1'b0;
            Err_Frame  <= 1'b0;
            Pkt_Drop   <= 1'b0;
        end else begin
            Err_Parity <= err_par_set;
            Err_Frame  <= err_frm_set;
            Pkt_Drop   <= 1'b0;
            if (pkt_done) begin
                if (!Pkt_Valid || Pkt_Ack) begin
                    Pkt_Valid <= 1'b1;
                    Buttons   <= hdr_q[2:0];
                    Dx        <= dx_new;
                    Dy        <= dy_new;
                end else begin
                    Pkt_Drop <= 1'b1;
                end
            end else if (Pkt_Valid && Pkt_Ack) begin
                Pkt_Valid <= 1'b0;
            end
        end
    end

endmodule
